// File: rtl/reset_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reset_sequencer_pkg
// Brief    : Shared state encoding, tick default and sizing helpers.
// Revision : 1.0 - initial release
// ============================================================================
package reset_sequencer_pkg;

    // Shared with the button debouncers: one tick per second at 50 MHz.
    localparam int c_TICK_MAX_DEFAULT = 50_000_000;

    localparam logic [1:0] c_ST_IDLE      = 2'd0;
    localparam logic [1:0] c_ST_ASSERT    = 2'd1;
    localparam logic [1:0] c_ST_WAIT_DONE = 2'd2;
    localparam logic [1:0] c_ST_COOLDOWN  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE      = c_ST_IDLE,
        ST_ASSERT    = c_ST_ASSERT,
        ST_WAIT_DONE = c_ST_WAIT_DONE,
        ST_COOLDOWN  = c_ST_COOLDOWN
    } state_t;

    function automatic int cnt_width(input int max_count);
        return (max_count > 1) ? $clog2(max_count) : 1;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/reset_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : reset_sequencer_if
// Brief    : Request/status bundle between the sequencer and its environment.
// Revision : 1.0 - initial release
// ============================================================================
interface reset_sequencer_if;

    logic       rst_req;
    logic       init_done;
    logic       sys_rst;
    logic       busy;
    logic       led;
    logic       timeout_err;
    logic [7:0] rst_count;

    modport master (
        input  rst_req,
        input  init_done,
        output sys_rst,
        output busy,
        output led,
        output timeout_err,
        output rst_count
    );

    modport slave (
        output rst_req,
        output init_done,
        input  sys_rst,
        input  busy,
        input  led,
        input  timeout_err,
        input  rst_count
    );

endinterface
`default_nettype wire

// File: rtl/tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : tick_gen
// Brief    : Restartable prescaler emitting a one-cycle tick every TICK_MAX clks.
// Revision : 1.0 - initial release
// ============================================================================
module tick_gen
    import reset_sequencer_pkg::*;
#(
    parameter int TICK_MAX = c_TICK_MAX_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int             c_W    = cnt_width(TICK_MAX);
    localparam logic [c_W-1:0] c_LAST = c_W'(TICK_MAX - 1);

    logic [c_W-1:0] r_presc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
        end else if (clear || tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    assign tick = (r_presc == c_LAST);

endmodule
`default_nettype wire

// File: rtl/reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : reset_sequencer
// Brief    : Turns a button reset request into a timed sys_rst pulse, waits for
//            init_done (with timeout), then locks out requests for a cooldown.
// Revision : 1.0 - initial release
// ============================================================================
module reset_sequencer
    import reset_sequencer_pkg::*;
#(
    parameter int TICK_MAX       = c_TICK_MAX_DEFAULT,
    parameter int RST_CYCLES     = 16,
    parameter int TIMEOUT_TICKS  = 5,
    parameter int COOLDOWN_TICKS = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    reset_sequencer_if.master   bus
);

    localparam int c_CNT_W = cnt_width(max3(RST_CYCLES, TIMEOUT_TICKS, COOLDOWN_TICKS));

    localparam logic [c_CNT_W-1:0] c_ASSERT_LAST   = c_CNT_W'(RST_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_TIMEOUT_LAST  = c_CNT_W'(TIMEOUT_TICKS - 1);
    localparam logic [c_CNT_W-1:0] c_COOLDOWN_LAST = c_CNT_W'(COOLDOWN_TICKS - 1);
    localparam logic [7:0]         c_COUNT_MAX     = 8'hFF;

    state_t               r_state;
    state_t               w_state_n;
    logic                 r_req_q;
    logic                 w_req;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_CNT_W-1:0]   w_cnt_n;
    logic                 w_tick;
    logic                 w_clear;
    logic                 r_sys_rst;
    logic                 r_busy;
    logic                 r_led;
    logic                 w_led_n;
    logic                 r_timeout_err;
    logic                 w_err_n;
    logic                 w_count_inc;
    logic [7:0]           r_rst_count;

    assign w_req = bus.rst_req & ~r_req_q;

    tick_gen #(
        .TICK_MAX (TICK_MAX)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (w_clear),
        .tick  (w_tick)
    );

    always_comb begin
        w_state_n   = r_state;
        w_err_n     = r_timeout_err;
        w_count_inc = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    w_state_n   = ST_ASSERT;
                    w_count_inc = 1'b1;
                end
            end
            ST_ASSERT: begin
                if (r_cnt == c_ASSERT_LAST) begin
                    w_state_n = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                // init_done takes priority over a coincident timeout tick.
                if (bus.init_done) begin
                    w_state_n = ST_COOLDOWN;
                    w_err_n   = 1'b0;
                end else if (w_tick && (r_cnt == c_TIMEOUT_LAST)) begin
                    w_state_n = ST_COOLDOWN;
                    w_err_n   = 1'b1;
                end
            end
            ST_COOLDOWN: begin
                if (w_tick && (r_cnt == c_COOLDOWN_LAST)) begin
                    w_state_n = ST_IDLE;
                end
            end
            default: begin
                w_state_n = ST_IDLE;
            end
        endcase

        // Timebase restarts on every state entry so each state length is exact.
        w_clear = (w_state_n != r_state) || (r_state == ST_IDLE);

        if (w_clear) begin
            w_cnt_n = '0;
        end else if ((r_state == ST_ASSERT) || w_tick) begin
            w_cnt_n = r_cnt + 1'b1;
        end else begin
            w_cnt_n = r_cnt;
        end

        if (w_state_n == ST_ASSERT) begin
            w_led_n = 1'b1;
        end else if (w_state_n == ST_IDLE) begin
            w_led_n = w_err_n;
        end else if (w_tick && (r_state != ST_ASSERT)) begin
            w_led_n = ~r_led;
        end else begin
            w_led_n = r_led;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_req_q       <= 1'b0;
            r_cnt         <= '0;
            r_sys_rst     <= 1'b0;
            r_busy        <= 1'b0;
            r_led         <= 1'b0;
            r_timeout_err <= 1'b0;
            r_rst_count   <= '0;
        end else begin
            r_state       <= w_state_n;
            r_req_q       <= bus.rst_req;
            r_cnt         <= w_cnt_n;
            r_sys_rst     <= (w_state_n == ST_ASSERT);
            r_busy        <= (w_state_n != ST_IDLE);
            r_led         <= w_led_n;
            r_timeout_err <= w_err_n;
            if (w_count_inc && (r_rst_count != c_COUNT_MAX)) begin
                r_rst_count <= r_rst_count + 1'b1;
            end
        end
    end

    assign bus.sys_rst     = r_sys_rst;
    assign bus.busy        = r_busy;
    assign bus.led         = r_led;
    assign bus.timeout_err = r_timeout_err;
    assign bus.rst_count   = r_rst_count;

endmodule
`default_nettype wire
